// File: rtl/mtx_ch_arb.sv
// Round-robin merge of NUM_CH valid/ready channels into one registered, channel-tagged beat stream.
// A single output register reloads on the same edge it drains, sustaining one beat per cycle.
module mtx_ch_arb #(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         test_mode_en,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    input  logic                         out_ready
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  load_en;
    logic                  any_valid;
    logic                  xfer;
    logic [NUM_CH-1:0]     rr_mask;
    logic [NUM_CH-1:0]     masked_valid;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       grant_rr;
    logic [CH_W-1:0]       grant_fixed;
    logic [CH_W-1:0]       rr_ptr_nxt;
    logic [DATA_WIDTH-1:0] grant_data;

    function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] vec);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    assign load_en   = ~out_valid_q | out_ready;
    assign any_valid = |in_valid;
    // Gated by reset so no channel sees an accept while the register is held clear.
    assign xfer      = sys_rst_n & load_en & any_valid;

    // Channels at or above the pointer are searched first; lower ones form the wrapped tail.
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_mask[i] = (32'(i) >= 32'(rr_ptr_q));
        end
    end

    assign masked_valid = in_valid & rr_mask;
    assign grant_fixed  = lowest_idx(in_valid);
    assign grant_rr     = (|masked_valid) ? lowest_idx(masked_valid) : grant_fixed;
    assign grant        = test_mode_en ? grant_fixed : grant_rr;
    assign rr_ptr_nxt   = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    assign grant_data   = in_data[32'(grant) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant;
            if (!test_mode_en) rr_ptr_d = rr_ptr_nxt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    a_ready_onehot: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        $onehot0(in_ready));

    a_rr_ptr_range: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        32'(rr_ptr_q) < NUM_CH);

    a_stall_stable: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        (out_valid_q && !out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_ch_q) && $stable(rr_ptr_q)));

endmodule

// File: tb/tb_mtx_ch_arb.sv
// Directed bench for mtx_ch_arb: reset, rotation, back-pressure, wrap, test mode,
// plus a randomised traffic run checked against a handshake scoreboard.
module tb_mtx_ch_arb;

    localparam int unsigned NUM_CH     = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CH_W       = 5;

    logic                         sys_clk;
    logic                         sys_rst_n;
    logic                         test_mode_en;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_ready;

    int n_checks = 0;
    int n_errors = 0;

    mtx_ch_arb #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .test_mode_en (test_mode_en),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_ready    (out_ready)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_data[i*DATA_WIDTH +: DATA_WIDTH] = 32'hA500_0000 | 32'(i);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [DATA_WIDTH-1:0] pat(input int ch);
        return 32'hA500_0000 | 32'(ch);
    endfunction

    task automatic apply_reset();
        in_valid     = '0;
        out_ready    = 1'b0;
        test_mode_en = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #2;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    logic [NUM_CH-1:0] v, acc;
    logic [CH_W-1:0]   sb[$];
    logic [CH_W-1:0]   exp_ch;
    int                n_push, n_pop;

    initial begin
        sys_rst_n    = 1'b0;
        test_mode_en = 1'b0;
        out_ready    = 1'b0;
        in_valid     = '1;

        // 1. Reset behaviour
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 0);
        check_eq("rst_out_ch", 64'(out_ch), 0);
        check_eq("rst_out_data", 64'(out_data), 0);
        check_eq("rst_in_ready", 64'(in_ready), 0);
        cyc();
        sys_rst_n = 1'b1;
        in_valid  = 32'h0000_0004;
        #1;
        check_eq("t1_ready_ch2", 64'(in_ready), 64'h4);
        cyc();
        check_eq("t1_valid", 64'(out_valid), 1);
        check_eq("t1_ch2", 64'(out_ch), 2);
        check_eq("t1_ptr3", 64'(dut.rr_ptr_q), 3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("t1_async_valid", 64'(out_valid), 0);
        check_eq("t1_async_ch", 64'(out_ch), 0);
        check_eq("t1_async_data", 64'(out_data), 0);
        check_eq("t1_async_ptr", 64'(dut.rr_ptr_q), 0);
        in_valid = 32'h0000_0009;
        cyc();
        sys_rst_n = 1'b1;
        #1;
        check_eq("t1_first_grant", 64'(in_ready), 64'h1);
        cyc();
        check_eq("t1_out_ch0", 64'(out_ch), 0);
        check_eq("t1_out_data0", 64'(out_data), 64'(pat(0)));
        in_valid  = '0;
        out_ready = 1'b1;
        cyc();
        check_eq("t1_drain", 64'(out_valid), 0);
        check_eq("t1_drain_hold", 64'(out_data), 64'(pat(0)));

        // 2. Full rotation with every channel valid
        apply_reset();
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 34; k++) begin
            cyc();
            check_eq("t2_valid", 64'(out_valid), 1);
            check_eq("t2_ch", 64'(out_ch), 64'(k % 32));
            check_eq("t2_data", 64'(out_data), 64'(pat(k % 32)));
        end
        in_valid = '0;
        cyc();

        // 3. Back-pressure with ch5 and ch9
        apply_reset();
        in_valid = 32'h0000_0220;
        #1;
        check_eq("t3_ready_ch5", 64'(in_ready), 64'h20);
        cyc();
        check_eq("t3_first_ch5", 64'(out_ch), 5);
        for (int s = 0; s < 4; s++) begin
            check_eq("t3_stall_ready", 64'(in_ready), 0);
            check_eq("t3_stall_ptr", 64'(dut.rr_ptr_q), 6);
            cyc();
            check_eq("t3_stall_valid", 64'(out_valid), 1);
            check_eq("t3_stall_ch", 64'(out_ch), 5);
            check_eq("t3_stall_data", 64'(out_data), 64'(pat(5)));
        end
        out_ready = 1'b1;
        cyc();
        check_eq("t3_next_ch9", 64'(out_ch), 9);
        cyc();
        check_eq("t3_then_ch5", 64'(out_ch), 5);
        check_eq("t3_valid_nobubble", 64'(out_valid), 1);

        // 4. Pointer wrap-around from 31
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 32'h4000_0000;
        cyc();
        check_eq("t4_ch30", 64'(out_ch), 30);
        check_eq("t4_ptr31", 64'(dut.rr_ptr_q), 31);
        in_valid = 32'h8000_0001;
        cyc();
        check_eq("t4_ch31", 64'(out_ch), 31);
        check_eq("t4_ptr0", 64'(dut.rr_ptr_q), 0);
        cyc();
        check_eq("t4_ch0", 64'(out_ch), 0);
        check_eq("t4_ptr1", 64'(dut.rr_ptr_q), 1);

        // 5. Fixed priority in test mode, then resume from saved pointer
        test_mode_en = 1'b1;
        in_valid     = 32'h0000_0088;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_eq("t5_tm_ch3", 64'(out_ch), 3);
            check_eq("t5_tm_ptr", 64'(dut.rr_ptr_q), 1);
        end
        test_mode_en = 1'b0;
        cyc();
        check_eq("t5_resume_ch3", 64'(out_ch), 3);
        cyc();
        check_eq("t5_resume_ch7", 64'(out_ch), 7);
        cyc();
        check_eq("t5_resume_ch3b", 64'(out_ch), 3);
        in_valid = '0;
        cyc();

        // 6. Random traffic against a handshake scoreboard
        apply_reset();
        v      = '0;
        acc    = '0;
        n_push = 0;
        n_pop  = 0;
        for (int c = 0; c < 400; c++) begin
            v         = (v & ~acc) | ($urandom() & $urandom() & $urandom());
            in_valid  = v;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                check_eq("t6_sb_nonempty", 64'(sb.size() > 0), 1);
                check_eq("t6_data_tag", 64'(out_data), 64'(pat(int'(out_ch))));
                if (sb.size() > 0) begin
                    exp_ch = sb.pop_front();
                    check_eq("t6_order", 64'(out_ch), 64'(exp_ch));
                    n_pop++;
                end
            end
            acc = in_valid & in_ready;
            check_eq("t6_ready_valid", 64'(in_ready & ~in_valid), 0);
            if (acc != '0) begin
                check_eq("t6_onehot", 64'($onehot(acc)), 1);
                for (int i = 0; i < NUM_CH; i++) begin
                    if (acc[i]) sb.push_back(CH_W'(i));
                end
                n_push++;
            end
            cyc();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (out_valid) begin
                check_eq("t6_drain_nonempty", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_ch = sb.pop_front();
                    check_eq("t6_drain_order", 64'(out_ch), 64'(exp_ch));
                    n_pop++;
                end
            end
            cyc();
        end
        check_eq("t6_sb_empty", 64'(sb.size()), 0);
        check_eq("t6_push_pop", 64'(n_pop), 64'(n_push));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
